// File: rtl/cache_control_if.sv
// Handshake and array-strobe bundle between the cache controller and its datapath.
// master is the controller side; slave is the datapath / memory side.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic hit0;
  logic hit1;
  logic lru;
  logic dirty;
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  logic way_sel;
  logic data_load;
  logic data_src;
  logic tag_load;
  logic valid_load;
  logic dirty_load;
  logic dirty_clear;
  logic lru_load;
  logic lru_mru;

  modport master (
    input  mem_read, mem_write, hit0, hit1, lru, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
           data_load, data_src, tag_load, valid_load, dirty_load,
           dirty_clear, lru_load, lru_mru
  );

  modport slave (
    output mem_read, mem_write, hit0, hit1, lru, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
           data_load, data_src, tag_load, valid_load, dirty_load,
           dirty_clear, lru_load, lru_mru
  );
endinterface

// File: rtl/cache_control.sv
// Sequencer for a 2-way, 8-set write-back cache: one-cycle hits, dirty-victim
// writeback followed by line allocation on a miss. Outputs are Mealy.
module cache_control (
  input logic             clk,
  input logic             reset,
  cache_control_if.master bus
);

  // state     | meaning
  // IDLE      | decode CPU request; serve hits, pick victim on miss
  // WRITEBACK | write dirty victim line to pmem
  // ALLOCATE  | read requested line from pmem into victim way
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;

  logic req;
  logic hit;

  assign req = bus.mem_read | bus.mem_write;
  assign hit = bus.hit0 | bus.hit1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.way_sel       = 1'b0;
    bus.data_load     = 1'b0;
    bus.data_src      = 1'b0;
    bus.tag_load      = 1'b0;
    bus.valid_load    = 1'b0;
    bus.dirty_load    = 1'b0;
    bus.dirty_clear   = 1'b0;
    bus.lru_load      = 1'b0;
    bus.lru_mru       = 1'b0;

    // Outputs are held quiet while reset is asserted so no array is strobed.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              bus.way_sel  = ~bus.hit0;
              bus.mem_resp = 1'b1;
              bus.lru_load = 1'b1;
              bus.lru_mru  = ~bus.hit0;
              if (bus.mem_write) begin
                bus.data_load  = 1'b1;
                bus.data_src   = 1'b1;
                bus.dirty_load = 1'b1;
              end
            end else begin
              bus.way_sel = bus.lru;
              victim_d    = bus.lru;
              state_d     = bus.dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.way_sel       = victim_q;
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          if (bus.pmem_resp) begin
            bus.dirty_clear = 1'b1;
            state_d         = ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.way_sel   = victim_q;
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.data_load   = 1'b1;
            bus.tag_load    = 1'b1;
            bus.valid_load  = 1'b1;
            bus.dirty_clear = 1'b1;
            state_d         = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed miss/hit scenarios followed by
// randomized cycles, all compared against a transaction-level reference model.
module tb_cache_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_control_if bus();

  cache_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bit positions in the packed output vector.
  localparam int MR = 12, PR = 11, PW = 10, AS = 9, WS = 8, DL = 7, DS = 6;
  localparam int TL = 5, VL = 4, DYL = 3, DC = 2, LL = 1, LM = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which pmem transfers of the current miss are still owed.
  bit owe_wb    = 0;
  bit owe_alloc = 0;
  bit m_victim  = 0;

  logic [12:0] obs;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input bit h0, input bit h1,
                       input bit l, input bit d, input bit pr);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit0      = h0;
    bus.hit1      = h1;
    bus.lru       = l;
    bus.dirty     = d;
    bus.pmem_resp = pr;
  endtask

  // One clock: predict outputs from the model, compare at negedge, advance model.
  task automatic step(input string tag);
    logic [12:0] e;
    bit nx_wb, nx_alloc, nx_vict;
    bit req, hit;
    @(negedge clk);
    e        = '0;
    nx_wb    = owe_wb;
    nx_alloc = owe_alloc;
    nx_vict  = m_victim;
    req      = bus.mem_read | bus.mem_write;
    hit      = bus.hit0 | bus.hit1;
    if (reset) begin
      nx_wb = 0; nx_alloc = 0; nx_vict = 0;
    end else if (owe_wb) begin
      e[PW] = 1; e[AS] = 1; e[WS] = m_victim;
      if (bus.pmem_resp) begin
        e[DC] = 1; nx_wb = 0; nx_alloc = 1;
      end
    end else if (owe_alloc) begin
      e[PR] = 1; e[WS] = m_victim;
      if (bus.pmem_resp) begin
        e[DL] = 1; e[TL] = 1; e[VL] = 1; e[DC] = 1; nx_alloc = 0;
      end
    end else if (req && hit) begin
      e[WS] = bus.hit0 ? 1'b0 : 1'b1;
      e[MR] = 1; e[LL] = 1; e[LM] = e[WS];
      if (bus.mem_write) begin
        e[DL] = 1; e[DS] = 1; e[DYL] = 1;
      end
    end else if (req) begin
      e[WS]   = bus.lru;
      nx_vict = bus.lru;
      if (bus.dirty) nx_wb = 1; else nx_alloc = 1;
    end
    obs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel,
           bus.way_sel, bus.data_load, bus.data_src, bus.tag_load,
           bus.valid_load, bus.dirty_load, bus.dirty_clear, bus.lru_load,
           bus.lru_mru};
    chk(tag, {3'b0, obs}, {3'b0, e});
    if (obs[PR] && obs[PW]) chk("pmem_exclusive", 16'd1, 16'd0);
    @(posedge clk);
    owe_wb    = nx_wb;
    owe_alloc = nx_alloc;
    m_victim  = nx_vict;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;

    // Reset cycle and the cycle after: everything quiet.
    step("reset_cycle");
    chk("reset_outs", {3'b0, obs}, 16'd0);
    reset = 1'b0;
    step("post_reset");
    chk("post_reset_outs", {3'b0, obs}, 16'd0);

    // Read hit in way 1.
    drive(1, 0, 0, 1, 0, 0, 0);
    step("rd_hit");
    chk("rd_hit_resp", obs[MR], 1);
    chk("rd_hit_way", obs[WS], 1);
    chk("rd_hit_lru_load", obs[LL], 1);
    chk("rd_hit_lru_mru", obs[LM], 1);
    chk("rd_hit_data_load", obs[DL], 0);

    // Write hit in way 0 (both hits set: way 0 wins).
    drive(0, 1, 1, 1, 1, 0, 0);
    step("wr_hit");
    chk("wr_hit_resp", obs[MR], 1);
    chk("wr_hit_way", obs[WS], 0);
    chk("wr_hit_merge", {obs[DL], obs[DS], obs[DYL]}, 3'b111);

    // Clean miss, lru=1, pmem_resp in cycle 4.
    drive(1, 0, 0, 0, 1, 0, 0);
    step("clean_miss_c0");
    chk("clean_miss_c0_resp", obs[MR], 0);
    for (int c = 1; c <= 4; c++) begin
      drive(1, 0, 0, 0, c[0], 0, c == 4);
      step("clean_alloc");
      chk("clean_alloc_pread", obs[PR], 1);
      chk("clean_alloc_way", obs[WS], 1);
    end
    chk("clean_alloc_fill", {obs[TL], obs[VL], obs[DL], obs[DS]}, 4'b1110);
    drive(1, 0, 0, 1, 0, 0, 0);
    step("clean_miss_c5");
    chk("clean_miss_c5_resp", obs[MR], 1);

    // Dirty miss, lru=0; lru toggles mid-miss.
    drive(0, 1, 0, 0, 0, 1, 0);
    step("dirty_miss_c0");
    for (int c = 1; c <= 2; c++) begin
      drive(0, 1, 0, 0, ~c[0], 1, c == 2);
      step("dirty_wb");
      chk("dirty_wb_pwrite", {obs[PW], obs[AS], obs[PR]}, 3'b110);
      chk("dirty_wb_way", obs[WS], 0);
    end
    chk("dirty_wb_clear", obs[DC], 1);
    for (int c = 3; c <= 4; c++) begin
      drive(0, 1, 0, 0, 1, 0, c == 4);
      step("dirty_alloc");
      chk("dirty_alloc_pread", {obs[PR], obs[AS], obs[PW]}, 3'b100);
      chk("dirty_alloc_way", obs[WS], 0);
    end
    drive(0, 1, 1, 0, 1, 0, 0);
    step("dirty_miss_c5");
    chk("dirty_miss_c5_resp", {obs[MR], obs[DL], obs[DS]}, 3'b111);

    // Reset mid-ALLOCATE.
    drive(1, 0, 0, 0, 1, 0, 0);
    step("rst_alloc_c0");
    step("rst_alloc_c1");
    reset = 1'b1;
    step("rst_alloc_c2");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step("rst_alloc_c3");
    chk("rst_alloc_c3_pread", obs[PR], 0);
    chk("rst_alloc_c3_resp", obs[MR], 0);

    // Request dropped during WRITEBACK.
    drive(1, 0, 0, 0, 1, 1, 0);
    step("drop_c0");
    drive(0, 0, 0, 0, 1, 1, 0);
    step("drop_wb1");
    drive(0, 0, 0, 0, 1, 1, 1);
    step("drop_wb2");
    chk("drop_wb_pwrite", obs[PW], 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("drop_alloc1");
    drive(0, 0, 0, 0, 0, 0, 1);
    step("drop_alloc2");
    chk("drop_alloc_fill", obs[TL], 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("drop_idle");
    chk("drop_idle_outs", {3'b0, obs}, 16'd0);

    // Randomized traffic, including pmem_resp in IDLE and stray resets.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
